ppg_dg412_drive_mc: RTL and testbench

//  Multi-channel DG412 switch driver with deadtime. Converts NCH logic-level clock phases
//  (cki) into complementary, non-overlapping ckop/ckon pairs for the DG412 analog switches.

---
 rtl/ppg_dg412_drive_mc.sv | 129 ++++++++++++
 tb/tb_ppg_dg412_drive_mc.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/ppg_dg412_drive_mc.sv
// Multi-channel DG412 switch driver: turns logic-level clock phases into complementary,
// non-overlapping ckop/ckon drives with programmable rise/fall deadtime and a latched fault kill.
module ppg_dg412_drive_mc #(
    parameter int NCH   = 4,
    parameter int WIDTH = 3
) (
    input  logic             clk_fast,
    input  logic             rst,
    input  logic             arm,
    input  logic             fault,
    input  logic             fault_clr,
    input  logic [NCH-1:0]   cki,
    input  logic [WIDTH-1:0] tdt_rise,
    input  logic [WIDTH-1:0] tdt_fall,
    output logic [NCH-1:0]   ckop,
    output logic [NCH-1:0]   ckon,
    output logic             armed,
    output logic             fault_latched
);

    typedef enum logic [2:0] {
        SAFE = 3'd0,
        LOW  = 3'd1,
        DT_R = 3'd2,
        HIGH = 3'd3,
        DT_F = 3'd4
    } state_t;

    state_t           st_q  [NCH];
    state_t           st_d  [NCH];
    logic [WIDTH-1:0] cnt_q [NCH];
    logic [WIDTH-1:0] cnt_d [NCH];

    logic arm_q;
    logic arm_d;
    logic fault_latched_q;
    logic fault_latched_d;
    logic kill;

    // A fault present on the same edge as fault_clr keeps the flag set.
    always_comb begin
        arm_d           = arm;
        fault_latched_d = fault_latched_q;
        if (fault) begin
            fault_latched_d = 1'b1;
        end else if (fault_clr) begin
            fault_latched_d = 1'b0;
        end
    end

    assign kill = ~arm_q | fault_latched_q | fault;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            st_d[i]  = st_q[i];
            cnt_d[i] = cnt_q[i];
            if (kill) begin
                st_d[i]  = SAFE;
                cnt_d[i] = '0;
            end else begin
                case (st_q[i])
                    SAFE, LOW, HIGH: begin
                        if (cki[i] && st_q[i] != HIGH) begin
                            cnt_d[i] = tdt_rise;
                            st_d[i]  = (tdt_rise == '0) ? HIGH : DT_R;
                        end else if (!cki[i] && st_q[i] != LOW) begin
                            cnt_d[i] = tdt_fall;
                            st_d[i]  = (tdt_fall == '0) ? LOW : DT_F;
                        end
                    end
                    DT_R: begin
                        if (!cki[i]) begin
                            st_d[i] = LOW;
                        end else if (cnt_q[i] == WIDTH'(1)) begin
                            st_d[i] = HIGH;
                        end else begin
                            cnt_d[i] = cnt_q[i] - WIDTH'(1);
                        end
                    end
                    DT_F: begin
                        if (cki[i]) begin
                            st_d[i] = HIGH;
                        end else if (cnt_q[i] == WIDTH'(1)) begin
                            st_d[i] = LOW;
                        end else begin
                            cnt_d[i] = cnt_q[i] - WIDTH'(1);
                        end
                    end
                    default: begin
                        st_d[i]  = SAFE;
                        cnt_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_fast) begin
        if (rst) begin
            arm_q           <= 1'b0;
            fault_latched_q <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                st_q[i]  <= SAFE;
                cnt_q[i] <= '0;
            end
        end else begin
            arm_q           <= arm_d;
            fault_latched_q <= fault_latched_d;
            for (int i = 0; i < NCH; i++) begin
                st_q[i]  <= st_d[i];
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // Raw fault reaches the pins through kill with no register in the path.
    always_comb begin
        ckop = '0;
        ckon = '0;
        for (int i = 0; i < NCH; i++) begin
            ckop[i] = (st_q[i] == HIGH) & ~kill;
            ckon[i] = (st_q[i] == LOW) & ~kill;
        end
    end

    assign armed         = arm_q & ~fault_latched_q;
    assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_ppg_dg412_drive_mc.sv
// Directed self-checking bench for ppg_dg412_drive_mc: reset, deadtime timing, aborts,
// zero-deadtime operation, fault latch/clear and deadtime capture on entry.
module tb_ppg_dg412_drive_mc;

    logic       clk_fast;
    logic       rst;
    logic       arm;
    logic       fault;
    logic       fault_clr;
    logic [3:0] cki;
    logic [2:0] tdt_rise;
    logic [2:0] tdt_fall;
    logic [3:0] ckop;
    logic [3:0] ckon;
    logic       armed;
    logic       fault_latched;

    int checks   = 0;
    int failures = 0;

    ppg_dg412_drive_mc #(.NCH(4), .WIDTH(3)) dut (
        .clk_fast      (clk_fast),
        .rst           (rst),
        .arm           (arm),
        .fault         (fault),
        .fault_clr     (fault_clr),
        .cki           (cki),
        .tdt_rise      (tdt_rise),
        .tdt_fall      (tdt_fall),
        .ckop          (ckop),
        .ckon          (ckon),
        .armed         (armed),
        .fault_latched (fault_latched)
    );

    initial clk_fast = 1'b0;
    always #5 clk_fast = ~clk_fast;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Drive cki, then step n edges; outputs are sampled 1 ns after each edge.
    task automatic applyStimulus(input logic [3:0] c, input int n);
        cki = c;
        for (int k = 0; k < n; k++) begin
            @(posedge clk_fast);
            #1;
            checkOutput("no_overlap", 32'(ckop & ckon), 32'd0);
        end
    endtask

    initial begin
        rst       = 1'b1;
        arm       = 1'b1;
        fault     = 1'b0;
        fault_clr = 1'b0;
        tdt_rise  = 3'd3;
        tdt_fall  = 3'd2;

        // Reset with all phases high and arm requested
        applyStimulus(4'hF, 2);
        checkOutput("rst_ckop", 32'(ckop), 32'h0);
        checkOutput("rst_ckon", 32'(ckon), 32'h0);
        checkOutput("rst_armed", 32'(armed), 32'd0);
        checkOutput("rst_flt", 32'(fault_latched), 32'd0);

        rst = 1'b0;
        applyStimulus(4'hF, 1);
        checkOutput("arm_r_armed", 32'(armed), 32'd1);
        checkOutput("arm_r_ckop", 32'(ckop), 32'h0);
        applyStimulus(4'hF, 3);
        checkOutput("safe_dtr_ckop", 32'(ckop), 32'h0);
        applyStimulus(4'hF, 1);
        checkOutput("safe_dtr_high", 32'(ckop), 32'hF);
        checkOutput("safe_dtr_ckon", 32'(ckon), 32'h0);

        // Channel 0 fall with tdt_fall=2, then rise with tdt_rise=3
        applyStimulus(4'hE, 1);
        checkOutput("fall_drop_ckop", 32'(ckop), 32'hE);
        checkOutput("fall_gap1_ckon", 32'(ckon), 32'h0);
        applyStimulus(4'hE, 1);
        checkOutput("fall_gap2_ckon", 32'(ckon), 32'h0);
        applyStimulus(4'hE, 1);
        checkOutput("fall_ckon_up", 32'(ckon), 32'h1);
        applyStimulus(4'hF, 1);
        checkOutput("rise_ckon_drop", 32'(ckon), 32'h0);
        checkOutput("rise_gap1_ckop", 32'(ckop), 32'hE);
        applyStimulus(4'hF, 2);
        checkOutput("rise_gap3_ckop", 32'(ckop), 32'hE);
        applyStimulus(4'hF, 1);
        checkOutput("rise_ckop_up", 32'(ckop), 32'hF);

        // Channel 1 short pulse aborts DT_R
        tdt_rise = 3'd4;
        applyStimulus(4'hD, 3);
        checkOutput("ch1_low_ckon", 32'(ckon), 32'h2);
        applyStimulus(4'hF, 1);
        checkOutput("abort_dtr_ckon", 32'(ckon), 32'h0);
        checkOutput("abort_dtr_ckop", 32'(ckop), 32'hD);
        applyStimulus(4'hD, 1);
        checkOutput("abort_low_ckon", 32'(ckon), 32'h2);
        applyStimulus(4'hD, 4);
        checkOutput("abort_no_ckop", 32'(ckop), 32'hD);

        // Zero deadtime: complementary with one-edge latency
        tdt_rise = 3'd0;
        tdt_fall = 3'd0;
        applyStimulus(4'b0110, 0);
        #1;
        checkOutput("zdt_pre_ckop", 32'(ckop), 32'hD);
        applyStimulus(4'b0110, 1);
        checkOutput("zdt1_ckop", 32'(ckop), 32'b0110);
        checkOutput("zdt1_ckon", 32'(ckon), 32'b1001);
        applyStimulus(4'b1001, 1);
        checkOutput("zdt2_ckop", 32'(ckop), 32'b1001);
        checkOutput("zdt2_ckon", 32'(ckon), 32'b0110);
        applyStimulus(4'b0101, 1);
        checkOutput("zdt3_ckop", 32'(ckop), 32'b0101);
        checkOutput("zdt3_ckon", 32'(ckon), 32'b1010);

        // Fault gates outputs immediately, then latches
        fault = 1'b1;
        #1;
        checkOutput("flt_comb_ckop", 32'(ckop), 32'h0);
        checkOutput("flt_comb_ckon", 32'(ckon), 32'h0);
        checkOutput("flt_comb_latch", 32'(fault_latched), 32'd0);
        applyStimulus(4'b0101, 1);
        checkOutput("flt_latched", 32'(fault_latched), 32'd1);
        checkOutput("flt_armed", 32'(armed), 32'd0);
        fault = 1'b0;
        applyStimulus(4'b0101, 1);
        checkOutput("flt_hold_ckop", 32'(ckop), 32'h0);
        checkOutput("flt_hold_latch", 32'(fault_latched), 32'd1);
        fault     = 1'b1;
        fault_clr = 1'b1;
        applyStimulus(4'b0101, 1);
        checkOutput("flt_clr_blocked", 32'(fault_latched), 32'd1);
        fault = 1'b0;
        applyStimulus(4'b0101, 1);
        checkOutput("flt_cleared", 32'(fault_latched), 32'd0);
        checkOutput("flt_rearmed", 32'(armed), 32'd1);
        checkOutput("flt_safe_ckon", 32'(ckon), 32'h0);
        fault_clr = 1'b0;
        tdt_rise  = 3'd2;
        tdt_fall  = 3'd3;
        applyStimulus(4'b0101, 2);
        checkOutput("reent_gap_ckop", 32'(ckop), 32'h0);
        checkOutput("reent_gap_ckon", 32'(ckon), 32'h0);
        applyStimulus(4'b0101, 1);
        checkOutput("reent_ckop", 32'(ckop), 32'b0101);
        checkOutput("reent_ckon_gap", 32'(ckon), 32'h0);
        applyStimulus(4'b0101, 1);
        checkOutput("reent_ckon", 32'(ckon), 32'b1010);

        // tdt_fall changed mid-deadtime only affects the next interval
        tdt_fall = 3'd2;
        applyStimulus(4'b0100, 1);
        checkOutput("cap_drop_ckop", 32'(ckop), 32'b0100);
        tdt_fall = 3'd7;
        applyStimulus(4'b0100, 1);
        checkOutput("cap_gap2_ckon", 32'(ckon), 32'b1010);
        applyStimulus(4'b0100, 1);
        checkOutput("cap_ckon_up", 32'(ckon), 32'b1011);
        tdt_rise = 3'd1;
        applyStimulus(4'b0101, 1);
        checkOutput("dt1_gap_ckop", 32'(ckop), 32'b0100);
        checkOutput("dt1_gap_ckon", 32'(ckon), 32'b1010);
        applyStimulus(4'b0101, 1);
        checkOutput("dt1_ckop", 32'(ckop), 32'b0101);
        for (int k = 0; k < 7; k++) begin
            applyStimulus(4'b0100, 1);
            checkOutput("max_dt_gap_ckon", 32'(ckon), 32'b1010);
        end
        applyStimulus(4'b0100, 1);
        checkOutput("max_dt_ckon_up", 32'(ckon), 32'b1011);
        checkOutput("max_dt_ckop", 32'(ckop), 32'b0100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
